// File: rtl/counter_298a_driver.sv
// rtl/counter_298a_driver.sv - bounce-sequence initiator and read-back checker for counter_298A
// Optional CNT_DRV_MISMATCH_HALT_EN: abort the run on the first read-back mismatch.
module counter_298a_driver #(
  parameter int W       = 8,
  parameter int BOUNCES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] y_in,
  output logic         en_o,
  output logic         load_o,
  output logic         up_o,
  output logic         oe_o,
  output logic [W-1:0] d_o,
  output logic         busy,
  output logic         done,
  output logic         cfg_err,
  output logic         mismatch,
  output logic [7:0]   err_cnt
);

  localparam int         BN_I = (BOUNCES < 1) ? 1 : BOUNCES;
  localparam logic [7:0] BN   = BN_I[7:0];

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UP, S_DN, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] lo_q, lo_d, hi_q, hi_d, m_q, m_d;
  logic [7:0]   bounce_q, bounce_d, err_cnt_q, err_cnt_d;
  logic         chk_vld_q, chk_vld_d, cfg_err_q, cfg_err_d, mismatch_q, mismatch_d;

  logic [W-1:0] m_inc, m_dec;
  logic [7:0]   bounce_inc;
  logic         bad;

  assign m_inc      = m_q + W'(1);
  assign m_dec      = m_q - W'(1);
  assign bounce_inc = bounce_q + 8'd1;
  // m_q is the counter value expected on y_in during this cycle.
  assign bad        = chk_vld_q && (y_in != m_q);

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    m_d        = m_q;
    bounce_d   = bounce_q;
    chk_vld_d  = chk_vld_q;
    cfg_err_d  = 1'b0;
    mismatch_d = mismatch_q;
    err_cnt_d  = err_cnt_q;

    if (bad) begin
      mismatch_d = 1'b1;
      err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (lo < hi) begin
            state_d    = S_LOAD;
            lo_d       = lo;
            hi_d       = hi;
            bounce_d   = 8'd0;
            mismatch_d = 1'b0;
            err_cnt_d  = 8'd0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        m_d       = lo_q;
        chk_vld_d = 1'b1;
        state_d   = S_UP;
      end
      S_UP: begin
        m_d = m_inc;
        if (m_inc == hi_q) state_d = S_DN;
      end
      S_DN: begin
        m_d = m_dec;
        if (m_dec == lo_q) begin
          bounce_d = bounce_inc;
          state_d  = (bounce_inc == BN) ? S_DONE : S_UP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef CNT_DRV_MISMATCH_HALT_EN
    if (bad) state_d = S_IDLE;
`else
`endif
    if (stop) state_d = S_IDLE;
    if (state_d == S_IDLE) chk_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      m_q        <= '0;
      bounce_q   <= 8'd0;
      chk_vld_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      m_q        <= m_d;
      bounce_q   <= bounce_d;
      chk_vld_q  <= chk_vld_d;
      cfg_err_q  <= cfg_err_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    en_o   = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DN);
    load_o = (state_q == S_LOAD);
    up_o   = (state_q != S_DN);
    oe_o   = (state_q != S_IDLE);
    d_o    = (state_q == S_LOAD) ? lo_q : '0;
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
  end

  assign cfg_err  = cfg_err_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_counter_298a_driver.sv
// tb/tb_counter_298a_driver.sv - scoreboard bench for counter_298a_driver with behavioural counters
module tb_counter_298a_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start1, stop, force0;
  logic [7:0] lo, hi, cnt0, cnt1, y0, y1;
  logic       en0, load0, up0, oe0, busy0, done0, cfg0, mm0;
  logic       en1, load1, up1, oe1, busy1, done1, cfg1, mm1;
  logic [7:0] d0, d1, ec0, ec1;
  logic [5:0] ctl0, ctl1;

  counter_298a_driver #(.W(8), .BOUNCES(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .lo(lo), .hi(hi), .y_in(y0),
    .en_o(en0), .load_o(load0), .up_o(up0), .oe_o(oe0), .d_o(d0), .busy(busy0),
    .done(done0), .cfg_err(cfg0), .mismatch(mm0), .err_cnt(ec0));

  counter_298a_driver #(.W(8), .BOUNCES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop), .lo(lo), .hi(hi), .y_in(y1),
    .en_o(en1), .load_o(load1), .up_o(up1), .oe_o(oe1), .d_o(d1), .busy(busy1),
    .done(done1), .cfg_err(cfg1), .mismatch(mm1), .err_cnt(ec1));

  // Ideal registered up/down counters; y0 can be overridden to inject read-back errors.
  always @(posedge clk) begin
    if (rst) cnt0 <= 8'd0;
    else if (en0) cnt0 <= load0 ? d0 : (up0 ? cnt0 + 8'd1 : cnt0 - 8'd1);
    if (rst) cnt1 <= 8'd0;
    else if (en1) cnt1 <= load1 ? d1 : (up1 ? cnt1 + 8'd1 : cnt1 - 8'd1);
  end

  assign y0   = force0 ? 8'h55 : cnt0;
  assign y1   = cnt1;
  assign ctl0 = {busy0, en0, load0, up0, oe0, done0};
  assign ctl1 = {busy1, en1, load1, up1, oe1, done1};

  localparam logic [5:0] IDLE_CTL = 6'b000100;

  typedef struct {
    logic [5:0] ctl;
    logic [7:0] d;
    bit         ychk;
    logic [7:0] y;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] c, input logic [7:0] dv, input bit yc, input logic [7:0] yv);
    exp_t e;
    e.ctl = c; e.d = dv; e.ychk = yc; e.y = yv;
    sb.push_back(e);
  endtask

  // Expected per-cycle {busy,en,load,up,oe,done}, d_o and y for one full run.
  task automatic push_run(input logic [7:0] l, input logic [7:0] h, input int b);
    push(6'b111110, l, 1'b0, 8'd0);
    for (int k = 0; k < b; k++) begin
      for (int v = l; v < h; v++) push(6'b110110, 8'd0, 1'b1, v[7:0]);
      for (int v = h; v > l; v--) push(6'b110010, 8'd0, 1'b1, v[7:0]);
    end
    push(6'b100111, 8'd0, 1'b1, l);
  endtask

  task automatic drain(input bit sel, input int n, input int fidx);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      force0 = (fidx >= 0) && (i == fidx || i == fidx + 1);
      #1;
      e = sb.pop_front();
      chk($sformatf("ctl%0d_%0d", sel, i), sel ? ctl1 : ctl0, e.ctl);
      chk($sformatf("d%0d_%0d", sel, i), sel ? d1 : d0, e.d);
      if (e.ychk && !force0) chk($sformatf("y%0d_%0d", sel, i), sel ? y1 : y0, e.y);
      tick();
    end
    force0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; stop = 1'b0; lo = 8'd0; hi = 8'd0; force0 = 1'b0;
    tick();
    tick();
    chk("rst_ctl", ctl0, IDLE_CTL);
    chk("rst_d", d0, 8'd0);
    chk("rst_cfg", cfg0, 1'b0);
    chk("rst_mm", mm0, 1'b0);
    chk("rst_ec", ec0, 8'd0);
    rst = 1'b0;
    tick();

    // Two bounces 3..6
    lo = 8'd3; hi = 8'd6; start = 1'b1;
    push_run(8'd3, 8'd6, 2);
    tick();
    start = 1'b0;
    drain(1'b0, sb.size(), -1);
    chk("t1_idle", ctl0, IDLE_CTL);
    chk("t1_mm", mm0, 1'b0);
    chk("t1_ec", ec0, 8'd0);

    // Rejected configurations
    lo = 8'd9; hi = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_cfg_pulse", cfg0, 1'b1);
    chk("t2_ctl", ctl0, IDLE_CTL);
    tick();
    chk("t2_cfg_clear", cfg0, 1'b0);
    lo = 8'd7; hi = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2b_cfg_pulse", cfg0, 1'b1);
    chk("t2b_ctl", ctl0, IDLE_CTL);

    // stop beats start in IDLE
    lo = 8'd3; hi = 8'd6; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_ctl", ctl0, IDLE_CTL);
    chk("ss_cfg", cfg0, 1'b0);

    // Minimal span, one bounce
    lo = 8'd0; hi = 8'd1; start1 = 1'b1;
    push_run(8'd0, 8'd1, 1);
    tick();
    start1 = 1'b0;
    drain(1'b1, sb.size(), -1);
    chk("t3_idle", ctl1, IDLE_CTL);
    chk("t3_other_idle", ctl0, IDLE_CTL);
    chk("t3_mm", mm1, 1'b0);

    // Injected read-back errors mid-UP
    lo = 8'd10; hi = 8'd20; start = 1'b1;
    push_run(8'd10, 8'd20, 2);
    tick();
    start = 1'b0;
`ifdef CNT_DRV_MISMATCH_HALT_EN
    drain(1'b0, 4, 3);
    chk("t4_halt_ctl", ctl0, IDLE_CTL);
    chk("t4_mm", mm0, 1'b1);
    chk("t4_ec", ec0, 8'd1);
    sb.delete();
`else
    drain(1'b0, sb.size(), 3);
    chk("t4_idle", ctl0, IDLE_CTL);
    chk("t4_mm", mm0, 1'b1);
    chk("t4_ec", ec0, 8'd2);
`endif

    // Abort by stop, then a normal rerun
    lo = 8'd3; hi = 8'd6; start = 1'b1;
    push_run(8'd3, 8'd6, 2);
    tick();
    start = 1'b0;
    drain(1'b0, 4, -1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    sb.delete();
    chk("t5_stop_ctl", ctl0, IDLE_CTL);
    chk("t5_mm", mm0, 1'b0);
    tick();
    chk("t5_no_done", ctl0, IDLE_CTL);
    start = 1'b1;
    push_run(8'd3, 8'd6, 2);
    tick();
    start = 1'b0;
    drain(1'b0, sb.size(), -1);
    chk("t5_rerun_idle", ctl0, IDLE_CTL);
    chk("t5_rerun_ec", ec0, 8'd0);

    // stop in the DONE cycle still gives the done pulse
    lo = 8'd0; hi = 8'd1; start1 = 1'b1;
    push_run(8'd0, 8'd1, 1);
    tick();
    start1 = 1'b0;
    drain(1'b1, 3, -1);
    stop = 1'b1;
    #1;
    chk("sd_done", ctl1, 6'b100111);
    tick();
    stop = 1'b0;
    sb.delete();
    chk("sd_idle", ctl1, IDLE_CTL);

    // Reset during DN
    lo = 8'd3; hi = 8'd6; start = 1'b1;
    push_run(8'd3, 8'd6, 2);
    tick();
    start = 1'b0;
`ifdef CNT_DRV_MISMATCH_HALT_EN
    drain(1'b0, 5, -1);
`else
    drain(1'b0, 5, 1);
    chk("t6_mm_pre", mm0, 1'b1);
    chk("t6_ec_pre", ec0, 8'd2);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("t6_ctl", ctl0, IDLE_CTL);
    chk("t6_d", d0, 8'd0);
    chk("t6_cfg", cfg0, 1'b0);
    chk("t6_mm", mm0, 1'b0);
    chk("t6_ec", ec0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
